// File: rtl/dot_pkg.sv
// Package for the NxN dot-product accumulator.
// Holds the elaboration helpers shared by the top and the lane multiplier:
//   acc_width  - accumulator width that cannot overflow for N*N*Channels products
//   kbs_legal  - legal kernel precisions (1, 2, 4, 8)
//   sat_clip   - clip a wide signed value to a signed bs-bit range, flagging clipping
package dot_pkg;

    // sat_clip works on longint, so the accumulator must fit in 64 bits.
    localparam int SAT_MAX_W = 64;

    function automatic int acc_width(input int n, input int bs, input int ch);
        return 2 * bs + $clog2(n * n * ch) + 1;
    endfunction

    function automatic bit kbs_legal(input int k);
        return (k == 1) || (k == 2) || (k == 4) || (k == 8);
    endfunction

    function automatic longint sat_clip(input longint v, input int bs, output logic sat);
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (bs - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (v > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (v < lo) begin
            sat = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dot_lane_mult.sv
// One lane of the dot product: signed data times a kernel coefficient.
// Purely combinational; the top registers the lane outputs.
//   i_x : signed data, BitSize bits
//   i_k : kernel, KernelBitSize bits (sign selector when KernelBitSize=1,
//         otherwise signed two's complement)
//   o_p : signed product, BitSize+KernelBitSize bits, after the fixed-point shift
module dot_lane_mult #(
    parameter int BitSize       = 8,
    parameter int KernelBitSize = 4,
    parameter int FixedPointPos = 0
) (
    input  logic [BitSize-1:0]               i_x,
    input  logic [KernelBitSize-1:0]         i_k,
    output logic [BitSize+KernelBitSize-1:0] o_p
);

    localparam int PW = BitSize + KernelBitSize;

    logic signed [PW-1:0] w_x;
    assign w_x = {{KernelBitSize{i_x[BitSize-1]}}, i_x};

    if (KernelBitSize == 1) begin : g_sign
        // Binary kernel: the bit only selects +x or -x. PW is one bit wider
        // than the data so negating the most negative input cannot wrap.
        assign o_p = i_k[0] ? w_x : -w_x;
    end else begin : g_mult
        logic signed [PW-1:0] w_k;
        logic signed [PW-1:0] w_full;
        assign w_k    = {{BitSize{i_k[KernelBitSize-1]}}, i_k};
        // |x*k| <= 2^(PW-2), so the PW-bit product never wraps.
        assign w_full = w_x * w_k;
        assign o_p    = w_full >>> FixedPointPos;
    end

endmodule

// File: rtl/dot_nxn_accum.sv
// NxN window dot product accumulated over Channels beats, saturated to BitSize.
// Pipeline: accept -> stage 1 (lane products) -> result register (accumulate
// and saturate) -> output register, giving out_valid two edges after the final
// beat of a group is accepted.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   beat handshake; kernel and in_data sampled on accept
//   kernel              lane i at [i*KernelBitSize +: KernelBitSize]
//   in_data             signed, lane i at [i*BitSize +: BitSize]
//   out_valid/out_ready result handshake; result held until consumed
//   out_sum, out_sat    saturated signed result and its clip flag
module dot_nxn_accum
    import dot_pkg::*;
#(
    parameter int N             = 3,
    parameter int BitSize       = 8,
    parameter int KernelBitSize = 4,
    parameter int FixedPointPos = 0,
    parameter int Channels      = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [KernelBitSize*N*N-1:0]    kernel,
    input  logic [BitSize*N*N-1:0]          in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BitSize-1:0]              out_sum,
    output logic                            out_sat
);

    localparam int L  = N * N;
    localparam int PW = BitSize + KernelBitSize;
    localparam int AW = acc_width(N, BitSize, Channels);
    localparam int CW = (Channels > 1) ? $clog2(Channels) : 1;

    if (!kbs_legal(KernelBitSize)) begin : g_err_kbs
        $error("dot_nxn_accum: KernelBitSize must be 1, 2, 4 or 8");
    end
    if (Channels < 1) begin : g_err_ch
        $error("dot_nxn_accum: Channels must be >= 1");
    end
    if (KernelBitSize > 1 && FixedPointPos >= KernelBitSize) begin : g_err_fpp
        $error("dot_nxn_accum: FixedPointPos must be below KernelBitSize");
    end
    if (AW > SAT_MAX_W) begin : g_err_aw
        $error("dot_nxn_accum: accumulator wider than the saturation helper");
    end

    logic                     w_in_ready;
    logic                     w_accept;
    logic [L-1:0][PW-1:0]     w_prod;
    logic [L-1:0][PW-1:0]     r_prod;
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic [CW-1:0]            r_chan;
    logic signed [AW-1:0]     r_acc;
    logic signed [AW-1:0]     w_lane_sum;
    logic signed [AW-1:0]     w_acc_sum;
    logic [BitSize-1:0]       w_sat_val;
    logic                     w_sat_flag;
    logic                     r_res_vld;
    logic [BitSize-1:0]       r_res_sum;
    logic                     r_res_sat;
    logic                     w_res_move;
    logic                     r_out_valid;
    logic [BitSize-1:0]       r_out_sum;
    logic                     r_out_sat;

    // A group's final beat in stage 1 blocks one accept, so only one result
    // can be travelling toward the output register at a time.
    assign w_in_ready = !(r_s1_valid && r_s1_last) && !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && w_in_ready;

    for (genvar i = 0; i < L; i++) begin : g_lane
        dot_lane_mult #(
            .BitSize       (BitSize),
            .KernelBitSize (KernelBitSize),
            .FixedPointPos (FixedPointPos)
        ) u_lane (
            .i_x (in_data[i*BitSize +: BitSize]),
            .i_k (kernel[i*KernelBitSize +: KernelBitSize]),
            .o_p (w_prod[i])
        );
    end

    // Stage 1: lane products plus group bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_chan     <= '0;
            r_prod     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept && (r_chan == CW'(Channels - 1));
            if (w_accept) begin
                r_prod <= w_prod;
                r_chan <= (r_chan == CW'(Channels - 1)) ? '0 : r_chan + 1'b1;
            end
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < L; i++) begin
            w_lane_sum = w_lane_sum + AW'($signed(r_prod[i]));
        end
    end

    assign w_acc_sum = r_acc + w_lane_sum;

    always_comb begin
        w_sat_flag = 1'b0;
        w_sat_val  = BitSize'(sat_clip(longint'(w_acc_sum), BitSize, w_sat_flag));
    end

    // Result register: closes a group and clears the accumulator so the
    // next group starts from zero.
    assign w_res_move = r_res_vld && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_res_vld <= 1'b0;
            r_res_sum <= '0;
            r_res_sat <= 1'b0;
        end else begin
            if (w_res_move) r_res_vld <= 1'b0;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_acc     <= '0;
                    r_res_vld <= 1'b1;
                    r_res_sum <= w_sat_val;
                    r_res_sat <= w_sat_flag;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    // Output register: held until consumed; a pending result loads on the
    // same edge the previous one is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_res_move) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= r_res_sum;
            r_out_sat   <= r_res_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_dot_nxn_accum.sv
// Directed bench for dot_nxn_accum with three configurations (N=3, BitSize=8):
//   A: KernelBitSize=4, Channels=2    B: KernelBitSize=1, Channels=1
//   C: KernelBitSize=8, FixedPointPos=4, Channels=1
// Expected results are queued as beats are driven and checked as they emerge.
module tb_dot_nxn_accum;

    typedef struct packed {
        logic [7:0] sum;
        logic       sat;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_ov, a_or, a_sat;
    logic [35:0] a_k;
    logic [71:0] a_d;
    logic [7:0]  a_sum;
    logic        b_iv, b_ir, b_ov, b_or, b_sat;
    logic [8:0]  b_k;
    logic [71:0] b_d;
    logic [7:0]  b_sum;
    logic        c_iv, c_ir, c_ov, c_or, c_sat;
    logic [71:0] c_k;
    logic [71:0] c_d;
    logic [7:0]  c_sum;

    res_t qa[$];
    res_t qb[$];
    res_t qc[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    dot_nxn_accum #(.N(3), .BitSize(8), .KernelBitSize(4), .FixedPointPos(0), .Channels(2)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .kernel(a_k), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum), .out_sat(a_sat));
    dot_nxn_accum #(.N(3), .BitSize(8), .KernelBitSize(1), .FixedPointPos(0), .Channels(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .kernel(b_k), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum), .out_sat(b_sat));
    dot_nxn_accum #(.N(3), .BitSize(8), .KernelBitSize(8), .FixedPointPos(4), .Channels(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .kernel(c_k), .in_data(c_d),
        .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum), .out_sat(c_sat));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] rep8(input logic [7:0] v);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [35:0] rep4(input logic [3:0] v);
        logic [35:0] r;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = v;
        return r;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic [3:0] k);
        int w;
        w = 0;
        a_iv = 1'b1; a_d = rep8(d); a_k = rep4(k);
        @(negedge clk);
        while (!a_ir && w < 50) begin @(negedge clk); w++; end
        if (!a_ir) check("a_accept_timeout", 32'd0, 32'd1);
        sync();
        a_iv = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [8:0] k);
        int w;
        w = 0;
        b_iv = 1'b1; b_d = rep8(d); b_k = k;
        @(negedge clk);
        while (!b_ir && w < 50) begin @(negedge clk); w++; end
        if (!b_ir) check("b_accept_timeout", 32'd0, 32'd1);
        sync();
        b_iv = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input logic [7:0] k);
        int w;
        w = 0;
        c_iv = 1'b1; c_d = rep8(d); c_k = rep8(k);
        @(negedge clk);
        while (!c_ir && w < 50) begin @(negedge clk); w++; end
        if (!c_ir) check("c_accept_timeout", 32'd0, 32'd1);
        sync();
        c_iv = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        sync();
    endtask

    // Scoreboard monitors: every consumed result must match the queue head.
    always @(negedge clk) begin
        res_t e;
        if (!reset && a_ov && a_or) begin
            if (qa.size() == 0) check("a_unexpected_result", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                check("a_sum", 32'(a_sum), 32'(e.sum));
                check("a_sat", 32'(a_sat), 32'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!reset && b_ov && b_or) begin
            if (qb.size() == 0) check("b_unexpected_result", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                check("b_sum", 32'(b_sum), 32'(e.sum));
                check("b_sat", 32'(b_sat), 32'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!reset && c_ov && c_or) begin
            if (qc.size() == 0) check("c_unexpected_result", 32'd1, 32'd0);
            else begin
                e = qc.pop_front();
                check("c_sum", 32'(c_sum), 32'(e.sum));
                check("c_sat", 32'(c_sat), 32'(e.sat));
            end
        end
    end

    initial begin
        int w;
        reset = 1'b1;
        a_iv = 1'b0; a_d = '0; a_k = '0; a_or = 1'b1;
        b_iv = 1'b0; b_d = '0; b_k = '0; b_or = 1'b1;
        c_iv = 1'b0; c_d = '0; c_k = '0; c_or = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_ov", 32'(a_ov), 32'd0);
        check("rst_a_sum", 32'(a_sum), 32'd0);
        check("rst_a_sat", 32'(a_sat), 32'd0);
        check("rst_b_ov", 32'(b_ov), 32'd0);
        check("rst_c_ov", 32'(c_ov), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_a_ir", 32'(a_ir), 32'd1);
        check("rst_b_ir", 32'(b_ir), 32'd1);
        check("rst_c_ir", 32'(c_ir), 32'd1);
        sync();

        // Ones times ones over two channels, with exact latency
        qa.push_back('{sum: 8'd18, sat: 1'b0});
        send_a(8'd1, 4'd1);
        send_a(8'd1, 4'd1);
        @(negedge clk);
        check("lat_ir_after_last", 32'(a_ir), 32'd0);
        check("lat_ov_t1", 32'(a_ov), 32'd0);
        @(negedge clk);
        check("lat_ov_t2", 32'(a_ov), 32'd0);
        @(negedge clk);
        check("lat_ov_t3", 32'(a_ov), 32'd1);
        sync();

        // Saturation both ways, and unsaturated negative sums
        qa.push_back('{sum: 8'd127, sat: 1'b1});
        send_a(8'd127, 4'd7);
        send_a(8'd127, 4'd7);
        qa.push_back('{sum: 8'h80, sat: 1'b1});
        send_a(8'h80, 4'd7);
        send_a(8'h80, 4'd7);
        qa.push_back('{sum: 8'h94, sat: 1'b0});
        send_a(8'd2, 4'hD);
        send_a(8'd2, 4'hD);
        qa.push_back('{sum: 8'h82, sat: 1'b0});
        send_a(8'd7, 4'hF);
        send_a(8'd7, 4'hF);
        drain();

        // Backpressure: first result held, second group enters after release
        a_or = 1'b0;
        qa.push_back('{sum: 8'd18, sat: 1'b0});
        send_a(8'd1, 4'd1);
        send_a(8'd1, 4'd1);
        w = 0;
        @(negedge clk);
        while (!a_ov && w < 10) begin @(negedge clk); w++; end
        check("bp_ov_arrives", 32'(a_ov), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ov_held", 32'(a_ov), 32'd1);
            check("bp_sum_held", 32'(a_sum), 32'd18);
            check("bp_ir_low", 32'(a_ir), 32'd0);
        end
        sync();
        a_or = 1'b1;
        qa.push_back('{sum: 8'd36, sat: 1'b0});
        send_a(8'd2, 4'd1);
        send_a(8'd2, 4'd1);
        @(negedge clk);
        check("bp_ir_after_last", 32'(a_ir), 32'd0);
        drain();

        // Reset discards an unconsumed result
        a_or = 1'b0;
        send_a(8'd3, 4'd1);
        send_a(8'd3, 4'd1);
        repeat (4) @(negedge clk);
        check("held_ov", 32'(a_ov), 32'd1);
        check("held_sum", 32'(a_sum), 32'd54);
        sync();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ov", 32'(a_ov), 32'd0);
        check("mid_rst_sum", 32'(a_sum), 32'd0);
        sync();
        reset = 1'b0;
        a_or = 1'b1;
        sync();

        // Reset discards a partial group
        send_a(8'd5, 4'd1);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        sync();
        qa.push_back('{sum: 8'd18, sat: 1'b0});
        send_a(8'd1, 4'd1);
        send_a(8'd1, 4'd1);
        drain();

        // Binary kernel
        qb.push_back('{sum: 8'hEE, sat: 1'b0});
        send_b(8'd2, 9'h000);
        qb.push_back('{sum: 8'd2, sat: 1'b0});
        send_b(8'd2, 9'h01F);
        qb.push_back('{sum: 8'd127, sat: 1'b1});
        send_b(8'h80, 9'h000);
        qb.push_back('{sum: 8'h80, sat: 1'b1});
        send_b(8'h80, 9'h1FF);
        drain();

        // 8-bit kernel with fixed-point shift of 4
        qc.push_back('{sum: 8'd27, sat: 1'b0});
        send_c(8'd3, 8'd16);
        qc.push_back('{sum: 8'hE5, sat: 1'b0});
        send_c(8'hFD, 8'd16);
        qc.push_back('{sum: 8'd0, sat: 1'b0});
        send_c(8'd1, 8'd8);
        qc.push_back('{sum: 8'hF7, sat: 1'b0});
        send_c(8'hFF, 8'd8);
        qc.push_back('{sum: 8'hA6, sat: 1'b0});
        send_c(8'd5, 8'hE0);
        drain();

        repeat (3) @(negedge clk);
        check("final_a_ov", 32'(a_ov), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
